// File: rtl/divide_tokens.sv
// Multi-channel token divider: passes one token out of every N per channel, with a
// saturating total of emitted tokens. Divisor changes apply only at group boundaries.
module divide_tokens #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    a,
  input  logic [DIV_W-1:0] div,
  input  logic             mode,
  input  logic             clr,
  output logic [CH-1:0]    b,
  output logic [CH-1:0]    pend,
  output logic [TOT_W-1:0] tot
);

  // Wide enough to hold tot plus a full-width popcount without overflow.
  localparam int unsigned SumW = TOT_W + $clog2(CH) + 1;
  localparam logic [SumW-1:0] TotMax = {{(SumW - TOT_W){1'b0}}, {TOT_W{1'b1}}};

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (div == '0) ? DIV_W'(1) : div;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DIV_W-1:0] ph_q, ph_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] ne;
    logic             at_first;
    logic             at_last;
    logic             tok;

    assign at_first = (ph_q == '0);
    assign ne       = at_first ? div_eff : n_q;
    assign at_last  = (ph_q == (ne - DIV_W'(1)));
    assign tok      = a[i] & ~clr;

    // Gating with rst keeps b quiet while reset is held, even in first-token mode.
    assign b[i]    = tok & rst & (mode ? at_first : at_last);
    assign pend[i] = ~at_first;

    always_comb begin
      ph_d = ph_q;
      n_d  = n_q;
      if (clr) begin
        ph_d = '0;
      end else if (a[i]) begin
        if (at_first) begin
          n_d = div_eff;
        end
        ph_d = at_last ? '0 : ph_q + DIV_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ph_q <= '0;
        n_q  <= DIV_W'(1);
      end else begin
        ph_q <= ph_d;
        n_q  <= n_d;
      end
    end
  end

  logic [SumW-1:0]  pop;
  logic [SumW-1:0]  sum;
  logic [TOT_W-1:0] tot_q, tot_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CH; i++) begin
      pop = pop + SumW'(b[i]);
    end
  end

  assign sum = {{(SumW - TOT_W){1'b0}}, tot_q} + pop;

  always_comb begin
    tot_d = tot_q;
    if (clr) begin
      tot_d = '0;
    end else if (sum > TotMax) begin
      tot_d = TotMax[TOT_W-1:0];
    end else begin
      tot_d = sum[TOT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tot_q <= '0;
    end else begin
      tot_q <= tot_d;
    end
  end

  assign tot = tot_q;

endmodule

// File: tb/tb_divide_tokens.sv
// Directed bench for divide_tokens: a default-sized instance, a narrow-total instance for
// saturation, and a CH=1/DIV_W=1 instance for the trivial divisor.
module tb_divide_tokens;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: CH=4, DIV_W=4, TOT_W=16
  logic [3:0]  a_m = '0, div_m = '0, b_m, pend_m;
  logic        mode_m = 1'b0, clr_m = 1'b0;
  logic [15:0] tot_m;

  // Saturation instance: CH=4, DIV_W=4, TOT_W=3
  logic [3:0]  a_s = '0, div_s = '0, b_s, pend_s;
  logic        mode_s = 1'b0, clr_s = 1'b0;
  logic [2:0]  tot_s;

  // Minimal instance: CH=1, DIV_W=1, TOT_W=16
  logic [0:0]  a_o = '0, div_o = '0, b_o, pend_o;
  logic        mode_o = 1'b0, clr_o = 1'b0;
  logic [15:0] tot_o;

  divide_tokens #(.CH(4), .DIV_W(4), .TOT_W(16)) u_main (
    .clk(clk), .rst(rst), .a(a_m), .div(div_m), .mode(mode_m), .clr(clr_m),
    .b(b_m), .pend(pend_m), .tot(tot_m)
  );

  divide_tokens #(.CH(4), .DIV_W(4), .TOT_W(3)) u_sat (
    .clk(clk), .rst(rst), .a(a_s), .div(div_s), .mode(mode_s), .clr(clr_s),
    .b(b_s), .pend(pend_s), .tot(tot_s)
  );

  divide_tokens #(.CH(1), .DIV_W(1), .TOT_W(16)) u_one (
    .clk(clk), .rst(rst), .a(a_o), .div(div_o), .mode(mode_o), .clr(clr_o),
    .b(b_o), .pend(pend_o), .tot(tot_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance and check the combinational b before the edge.
  task automatic step_m(input logic [3:0] a, input logic clr, input logic [3:0] eb,
                        input string tag);
    @(negedge clk);
    a_m   = a;
    clr_m = clr;
    #1 chk(tag, {28'd0, b_m}, {28'd0, eb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: state clear and b forced low even with tokens in first-token mode.
    a_m = 4'b1111; mode_m = 1'b1; a_o = 1'b1; mode_o = 1'b1; a_s = 4'b1111; mode_s = 1'b1;
    #2;
    chk("rst_b_main", {28'd0, b_m}, 32'd0);
    chk("rst_pend_main", {28'd0, pend_m}, 32'd0);
    chk("rst_tot_main", {16'd0, tot_m}, 32'd0);
    chk("rst_b_sat", {28'd0, b_s}, 32'd0);
    chk("rst_b_one", {31'd0, b_o}, 32'd0);
    @(posedge clk);
    #1 chk("rst_hold_tot", {16'd0, tot_m}, 32'd0);
    @(negedge clk);
    a_m = '0; a_s = '0; a_o = '0; mode_m = 1'b0; mode_s = 1'b0; mode_o = 1'b0;
    rst = 1'b1;

    // Saturation: 4 tokens per cycle, divisor 1, 3-bit total -> 4, 7, 7.
    div_s = 4'd1;
    @(negedge clk); a_s = 4'b1111;
    #1 chk("sat_b", {28'd0, b_s}, 32'hf);
    @(posedge clk); #1 chk("sat_tot1", {29'd0, tot_s}, 32'd4);
    @(posedge clk); #1 chk("sat_tot2", {29'd0, tot_s}, 32'd7);
    @(posedge clk); #1 chk("sat_tot3", {29'd0, tot_s}, 32'd7);
    @(negedge clk); a_s = '0;

    // CH=1, DIV_W=1: div 0 and 1 both pass every token in both modes.
    div_o = 1'b0; mode_o = 1'b0;
    @(negedge clk); a_o = 1'b1;
    #1 chk("one_d0_m0", {31'd0, b_o}, 32'd1);
    @(negedge clk); mode_o = 1'b1;
    #1 chk("one_d0_m1", {31'd0, b_o}, 32'd1);
    @(negedge clk); div_o = 1'b1;
    #1 chk("one_d1_m1", {31'd0, b_o}, 32'd1);
    @(negedge clk); mode_o = 1'b0;
    #1 chk("one_d1_m0", {31'd0, b_o}, 32'd1);
    @(negedge clk); a_o = 1'b0;
    #1 chk("one_tot", {16'd0, tot_o}, 32'd4);
    chk("one_pend", {31'd0, pend_o}, 32'd0);

    // div=3, mode 0, 7 tokens: 0,0,1,0,0,1,0.
    div_m = 4'd3; mode_m = 1'b0;
    step_m(4'b0001, 1'b0, 4'b0000, "d3m0_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m0_t2");
    step_m(4'b0001, 1'b0, 4'b0001, "d3m0_t3");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m0_t4");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m0_t5");
    step_m(4'b0001, 1'b0, 4'b0001, "d3m0_t6");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m0_t7");
    chk("d3m0_tot", {16'd0, tot_m}, 32'd2);
    chk("d3m0_pend", {28'd0, pend_m}, 32'h1);
    step_m(4'b0000, 1'b1, 4'b0000, "clr1");
    chk("clr1_tot", {16'd0, tot_m}, 32'd0);
    chk("clr1_pend", {28'd0, pend_m}, 32'd0);

    // div=3, mode 1, 6 tokens: 1,0,0,1,0,0.
    mode_m = 1'b1;
    step_m(4'b0001, 1'b0, 4'b0001, "d3m1_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m1_t2");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m1_t3");
    step_m(4'b0001, 1'b0, 4'b0001, "d3m1_t4");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m1_t5");
    step_m(4'b0001, 1'b0, 4'b0000, "d3m1_t6");
    chk("d3m1_tot", {16'd0, tot_m}, 32'd2);
    chk("d3m1_pend", {28'd0, pend_m}, 32'd0);
    step_m(4'b0000, 1'b1, 4'b0000, "clr2");

    // Divisor change mid-group waits for the boundary: 4th and 6th tokens emit.
    mode_m = 1'b0; div_m = 4'd4;
    step_m(4'b0001, 1'b0, 4'b0000, "dchg_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "dchg_t2");
    div_m = 4'd2;
    step_m(4'b0001, 1'b0, 4'b0000, "dchg_t3");
    step_m(4'b0001, 1'b0, 4'b0001, "dchg_t4");
    step_m(4'b0001, 1'b0, 4'b0000, "dchg_t5");
    step_m(4'b0001, 1'b0, 4'b0001, "dchg_t6");
    chk("dchg_tot", {16'd0, tot_m}, 32'd2);
    step_m(4'b0000, 1'b1, 4'b0000, "clr3");

    // All channels, div=2: 0000,1111,0000,1111, tot=8.
    step_m(4'b1111, 1'b0, 4'b0000, "all_t1");
    step_m(4'b1111, 1'b0, 4'b1111, "all_t2");
    step_m(4'b1111, 1'b0, 4'b0000, "all_t3");
    step_m(4'b1111, 1'b0, 4'b1111, "all_t4");
    chk("all_tot", {16'd0, tot_m}, 32'd8);
    step_m(4'b0000, 1'b1, 4'b0000, "clr4");

    // Independent channels with disjoint token patterns.
    step_m(4'b0101, 1'b0, 4'b0000, "ind_t1");
    step_m(4'b0011, 1'b0, 4'b0001, "ind_t2");
    chk("ind_pend", {28'd0, pend_m}, 32'h6);
    step_m(4'b0000, 1'b1, 4'b0000, "clr5");

    // Mode flipped mid-group does not disturb the phase.
    div_m = 4'd3;
    step_m(4'b0001, 1'b0, 4'b0000, "mflip_t1");
    mode_m = 1'b1;
    step_m(4'b0001, 1'b0, 4'b0000, "mflip_t2");
    mode_m = 1'b0;
    step_m(4'b0001, 1'b0, 4'b0001, "mflip_t3");
    step_m(4'b0000, 1'b1, 4'b0000, "clr6");

    // div=0 acts as N=1 in both modes.
    div_m = 4'd0;
    step_m(4'b1111, 1'b0, 4'b1111, "d0_m0");
    mode_m = 1'b1;
    step_m(4'b1111, 1'b0, 4'b1111, "d0_m1");
    chk("d0_pend", {28'd0, pend_m}, 32'd0);
    mode_m = 1'b0;
    step_m(4'b0000, 1'b1, 4'b0000, "clr7");

    // clr overrides a token mid-group.
    div_m = 4'd5;
    step_m(4'b0001, 1'b0, 4'b0000, "clrmid_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "clrmid_t2");
    step_m(4'b0001, 1'b0, 4'b0000, "clrmid_t3");
    step_m(4'b0001, 1'b1, 4'b0000, "clrmid_b");
    chk("clrmid_pend", {28'd0, pend_m}, 32'd0);
    chk("clrmid_tot", {16'd0, tot_m}, 32'd0);

    // Same with reset: first bank an emitted token so the total is non-zero.
    div_m = 4'd1;
    step_m(4'b0001, 1'b0, 4'b0001, "rstmid_pre");
    chk("rstmid_pre_tot", {16'd0, tot_m}, 32'd1);
    div_m = 4'd5;
    step_m(4'b0001, 1'b0, 4'b0000, "rstmid_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "rstmid_t2");
    step_m(4'b0001, 1'b0, 4'b0000, "rstmid_t3");
    chk("rstmid_pend_before", {28'd0, pend_m}, 32'h1);
    @(negedge clk);
    a_m = 4'b0001;
    rst = 1'b0;
    #1;
    chk("rstmid_b", {28'd0, b_m}, 32'd0);
    chk("rstmid_pend", {28'd0, pend_m}, 32'd0);
    chk("rstmid_tot", {16'd0, tot_m}, 32'd0);
    @(posedge clk);
    #1 chk("rstmid_pend_hold", {28'd0, pend_m}, 32'd0);
    @(negedge clk);
    a_m = '0;
    rst = 1'b1;
    step_m(4'b0001, 1'b0, 4'b0000, "post_t1");
    step_m(4'b0001, 1'b0, 4'b0000, "post_t2");
    step_m(4'b0001, 1'b0, 4'b0000, "post_t3");
    step_m(4'b0001, 1'b0, 4'b0000, "post_t4");
    step_m(4'b0001, 1'b0, 4'b0001, "post_t5");
    chk("post_tot", {16'd0, tot_m}, 32'd1);
    chk("post_pend", {28'd0, pend_m}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
